// File: rtl/sseg_scan_mux_if.sv
// Signal bundle between a digit source (stopwatch) and the seven-segment scan driver.
// The master drives the digit values and decimal points; the slave drives the board pins.
interface sseg_scan_mux_if;
  logic [3:0] i_hex3;
  logic [3:0] i_hex2;
  logic [3:0] i_hex1;
  logic [3:0] i_hex0;
  logic [3:0] i_dp;
  logic [3:0] o_an;
  logic [7:0] o_sseg;
  logic       o_frame;

  modport master (
    output i_hex3, i_hex2, i_hex1, i_hex0, i_dp,
    input  o_an, o_sseg, o_frame
  );

  modport slave (
    input  i_hex3, i_hex2, i_hex1, i_hex0, i_dp,
    output o_an, o_sseg, o_frame
  );
endinterface

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Digits are latched once per frame into shadow registers so a counter rollover
// in the middle of a scan never shows a torn value, and every digit slot starts
// with a short all-off gap that hides ghosting while the anodes switch.
// Optional leading-zero blanking is enabled by defining the macro SSEG_LZB_EN.
module sseg_scan_mux #(
  parameter int DIG_CYCLES   = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic           i_clk,
  input logic           i_rst,
  sseg_scan_mux_if.slave bus
);

  localparam int CW = $clog2(DIG_CYCLES);

  // Cycle counter inside the current slot and the active digit slot
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;

  // Frame snapshot of the digit values and decimal points
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      dp_q, dp_d;

  // Registered pin drivers
  logic [3:0]      an_q, an_d;
  logic [7:0]      sseg_q, sseg_d;
  logic            frame_q, frame_d;

  logic            cntLast;
  logic            snapNow;
  logic            inBlank;
  logic [3:0]      curDigit;
  logic            curDp;
  logic [3:0]      lzbBlank;

  // Active-high a..g pattern for one hex digit; inverted later for the common-anode pins
  function automatic logic [6:0] decodeHex(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Leading-zero flags, derived from the frozen snapshot so they cannot flicker mid-frame
  always_comb begin
    lzbBlank = 4'b0000;
`ifdef SSEG_LZB_EN
    lzbBlank[3] = (shadow_q[3] == 4'h0) && !dp_q[3];
    lzbBlank[2] = lzbBlank[3] && (shadow_q[2] == 4'h0) && !dp_q[2];
    lzbBlank[1] = lzbBlank[2] && (shadow_q[1] == 4'h0) && !dp_q[1];
    lzbBlank[0] = 1'b0;
`else
    lzbBlank = 4'b0000;
`endif
  end

  // Scan timing, frame snapshot and next pin values; pins are computed from the
  // current (sel, cnt, shadow) and appear one cycle later
  always_comb begin
    cntLast  = (cnt_q == CW'(DIG_CYCLES - 1));
    snapNow  = (cnt_q == '0) && (sel_q == 2'd0);
    inBlank  = (cnt_q < CW'(BLANK_CYCLES));
    curDigit = shadow_q[sel_q];
    curDp    = dp_q[sel_q];

    cnt_d    = cntLast ? '0 : cnt_q + CW'(1);
    sel_d    = cntLast ? sel_q + 2'd1 : sel_q;

    shadow_d = shadow_q;
    dp_d     = dp_q;
    if (snapNow) begin
      shadow_d = {bus.i_hex3, bus.i_hex2, bus.i_hex1, bus.i_hex0};
      dp_d     = bus.i_dp;
    end

    an_d   = 4'b1111;
    sseg_d = 8'hFF;
    if (!inBlank && !lzbBlank[sel_q]) begin
      an_d   = ~(4'b0001 << sel_q);
      sseg_d = {~curDp, ~decodeHex(curDigit)};
    end

    frame_d = snapNow;
  end

  // State and pin registers; reset forces all segments dark and restarts at slot 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= '0;
      dp_q     <= 4'b0000;
      an_q     <= 4'b1111;
      sseg_q   <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.o_an    = an_q;
  assign bus.o_sseg  = sseg_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for the seven-segment scan driver with a short 4-cycle slot
// and 1-cycle blanking gap, so one frame is 16 clock cycles.
module tb_sseg_scan_mux;

  logic i_clk;
  logic i_rst;

  sseg_scan_mux_if bus();

  sseg_scan_mux #(
    .DIG_CYCLES   (4),
    .BLANK_CYCLES (1)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int nChecks;
  int nErrors;
  int curEdge;
  int nextEdge;

  // Inverted segment patterns for 0..F with the decimal point off
  logic [7:0] segTbl [16];

  // 100 MHz-style free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    curEdge  = nextEdge;
    nextEdge = nextEdge + 1;
  endtask

  task automatic test_reset();
    logic [3:0] anSeq [16];
    logic [7:0] digSeg [4];
    logic [7:0] expSeg;
    anSeq  = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
               4'b1111, 4'b1101, 4'b1101, 4'b1101,
               4'b1111, 4'b1011, 4'b1011, 4'b1011,
               4'b1111, 4'b0111, 4'b0111, 4'b0111};
    digSeg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    i_rst = 1'b1;
    bus.i_hex3 = 4'h1; bus.i_hex2 = 4'h2; bus.i_hex1 = 4'h3; bus.i_hex0 = 4'h4;
    bus.i_dp = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      tick();
      nChecks++;
      if (bus.o_an !== 4'b1111) begin
        nErrors++; $display("[TB] FAIL reset_an: got %b expected 1111", bus.o_an);
      end
      nChecks++;
      if (bus.o_sseg !== 8'hFF) begin
        nErrors++; $display("[TB] FAIL reset_sseg: got %h expected ff", bus.o_sseg);
      end
      nChecks++;
      if (bus.o_frame !== 1'b0) begin
        nErrors++; $display("[TB] FAIL reset_frame: got %b expected 0", bus.o_frame);
      end
    end
    i_rst = 1'b0;
    nextEdge = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      expSeg = (k % 4 == 0) ? 8'hFF : digSeg[k / 4];
      nChecks++;
      if (bus.o_an !== anSeq[k]) begin
        nErrors++; $display("[TB] FAIL scan_an[%0d]: got %b expected %b", k, bus.o_an, anSeq[k]);
      end
      nChecks++;
      if (bus.o_sseg !== expSeg) begin
        nErrors++; $display("[TB] FAIL scan_sseg[%0d]: got %h expected %h", k, bus.o_sseg, expSeg);
      end
      nChecks++;
      if (bus.o_frame !== (k == 0)) begin
        nErrors++; $display("[TB] FAIL scan_frame[%0d]: got %b expected %b", k, bus.o_frame, (k == 0));
      end
    end
  endtask

  task automatic test_snapshot_coherence();
    int slot;
    int c;
    logic [7:0] expSeg;
    logic [3:0] expAn;
    while (nextEdge < 48) begin
      if (nextEdge == 24) begin
        bus.i_hex0 = 4'h9;
        bus.i_hex3 = 4'h8;
      end
      tick();
      slot = (curEdge % 16) / 4;
      c    = curEdge % 4;
      case (slot)
        0:       expSeg = (curEdge < 32) ? 8'h99 : 8'h90;
        1:       expSeg = 8'hB0;
        2:       expSeg = 8'hA4;
        default: expSeg = (curEdge < 32) ? 8'hF9 : 8'h80;
      endcase
      expAn = ~(4'b0001 << slot);
      if (c == 0) begin
        expSeg = 8'hFF;
        expAn  = 4'b1111;
      end
      nChecks++;
      if (bus.o_an !== expAn) begin
        nErrors++; $display("[TB] FAIL snap_an[%0d]: got %b expected %b", curEdge, bus.o_an, expAn);
      end
      nChecks++;
      if (bus.o_sseg !== expSeg) begin
        nErrors++; $display("[TB] FAIL snap_sseg[%0d]: got %h expected %h", curEdge, bus.o_sseg, expSeg);
      end
      nChecks++;
      if (bus.o_frame !== (curEdge % 16 == 0)) begin
        nErrors++; $display("[TB] FAIL snap_frame[%0d]: got %b expected %b", curEdge, bus.o_frame, (curEdge % 16 == 0));
      end
    end
  endtask

  task automatic test_decimal_point();
    logic [7:0] slotSeg [4];
    logic [7:0] expSeg;
    logic [3:0] expAn;
    int slot;
    slotSeg = '{8'h90, 8'hB0, 8'h12, 8'h80};
    bus.i_hex2 = 4'h5;
    bus.i_dp   = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      tick();
      slot   = k / 4;
      expSeg = (k % 4 == 0) ? 8'hFF : slotSeg[slot];
      expAn  = (k % 4 == 0) ? 4'b1111 : ~(4'b0001 << slot);
      nChecks++;
      if (bus.o_an !== expAn) begin
        nErrors++; $display("[TB] FAIL dp_an[%0d]: got %b expected %b", k, bus.o_an, expAn);
      end
      nChecks++;
      if (bus.o_sseg !== expSeg) begin
        nErrors++; $display("[TB] FAIL dp_sseg[%0d]: got %h expected %h", k, bus.o_sseg, expSeg);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [3:0] v4;
    bus.i_dp = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      v4 = v[3:0];
      bus.i_hex0 = v4;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (k == 2) begin
          nChecks++;
          if (bus.o_sseg !== segTbl[v]) begin
            nErrors++; $display("[TB] FAIL decode[%0d]: got %h expected %h", v, bus.o_sseg, segTbl[v]);
          end
          nChecks++;
          if (bus.o_an !== 4'b1110) begin
            nErrors++; $display("[TB] FAIL decode_an[%0d]: got %b expected 1110", v, bus.o_an);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic [7:0] expSeg;
    logic [3:0] expAn;
    while (nextEdge % 16 != 10) tick();
    i_rst = 1'b1;
    bus.i_hex3 = 4'h5; bus.i_hex2 = 4'h6; bus.i_hex1 = 4'h7; bus.i_hex0 = 4'h8;
    tick();
    nChecks++;
    if (bus.o_an !== 4'b1111) begin
      nErrors++; $display("[TB] FAIL midrst_an: got %b expected 1111", bus.o_an);
    end
    nChecks++;
    if (bus.o_sseg !== 8'hFF) begin
      nErrors++; $display("[TB] FAIL midrst_sseg: got %h expected ff", bus.o_sseg);
    end
    nChecks++;
    if (bus.o_frame !== 1'b0) begin
      nErrors++; $display("[TB] FAIL midrst_frame: got %b expected 0", bus.o_frame);
    end
    i_rst = 1'b0;
    nextEdge = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      expSeg = (k % 4 == 0) ? 8'hFF : ((k < 4) ? 8'h80 : 8'hF8);
      expAn  = (k % 4 == 0) ? 4'b1111 : ((k < 4) ? 4'b1110 : 4'b1101);
      nChecks++;
      if (bus.o_an !== expAn) begin
        nErrors++; $display("[TB] FAIL restart_an[%0d]: got %b expected %b", k, bus.o_an, expAn);
      end
      nChecks++;
      if (bus.o_sseg !== expSeg) begin
        nErrors++; $display("[TB] FAIL restart_sseg[%0d]: got %h expected %h", k, bus.o_sseg, expSeg);
      end
      nChecks++;
      if (bus.o_frame !== (k == 0)) begin
        nErrors++; $display("[TB] FAIL restart_frame[%0d]: got %b expected %b", k, bus.o_frame, (k == 0));
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] expS [3][4];
    logic [3:0] hex0Val [3];
    logic [3:0] dpVal [3];
    logic [7:0] expSeg;
    logic [3:0] expAn;
    int slot;
`ifdef SSEG_LZB_EN
    expS[0] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
    expS[1] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    expS[2] = '{8'hC0, 8'h40, 8'hFF, 8'hFF};
`else
    expS[0] = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
    expS[1] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    expS[2] = '{8'hC0, 8'h40, 8'hC0, 8'hC0};
`endif
    hex0Val = '{4'h7, 4'h0, 4'h0};
    dpVal   = '{4'b0000, 4'b0000, 4'b0010};
    while (nextEdge % 16 != 0) tick();
    for (int s = 0; s < 3; s++) begin
      bus.i_hex3 = 4'h0; bus.i_hex2 = 4'h0; bus.i_hex1 = 4'h0;
      bus.i_hex0 = hex0Val[s];
      bus.i_dp   = dpVal[s];
      for (int k = 0; k < 16; k++) begin
        tick();
        slot = k / 4;
        if ((k % 4 == 0) || (expS[s][slot] == 8'hFF)) begin
          expSeg = 8'hFF;
          expAn  = 4'b1111;
        end else begin
          expSeg = expS[s][slot];
          expAn  = ~(4'b0001 << slot);
        end
        nChecks++;
        if (bus.o_an !== expAn) begin
          nErrors++; $display("[TB] FAIL lzb_an[%0d][%0d]: got %b expected %b", s, k, bus.o_an, expAn);
        end
        nChecks++;
        if (bus.o_sseg !== expSeg) begin
          nErrors++; $display("[TB] FAIL lzb_sseg[%0d][%0d]: got %h expected %h", s, k, bus.o_sseg, expSeg);
        end
      end
    end
  endtask

  // Runs every scenario in order and prints the summary
  initial begin
    nChecks  = 0;
    nErrors  = 0;
    curEdge  = 0;
    nextEdge = 0;
    segTbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    i_rst = 1'b1;
    bus.i_hex3 = 4'h0; bus.i_hex2 = 4'h0; bus.i_hex1 = 4'h0; bus.i_hex0 = 4'h0;
    bus.i_dp   = 4'b0000;
    test_reset();
    test_snapshot_coherence();
    test_decimal_point();
    test_decode_sweep();
    test_reset_midscan();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
